// File: rtl/imem_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_if
//  Description : Bundles the ROM port, redirect request and decode handshake
//                of the instruction fetch sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_fetch_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        out_ready;
    logic        done;
    logic        err;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready,
        output done,
        output err
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready,
        input  done,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction fetch sequencer with a PC/instruction FIFO,
//                flush-on-redirect, end-of-memory drain and sticky error.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter int          MEM_SIZE = 1024,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    imem_fetch_if.master  bus
);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [15:0]       LAST_PC   = 16'(MEM_SIZE - 4);
    localparam logic [16:0]       MEM_LIMIT = 17'(MEM_SIZE);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        instr_mem_q [DEPTH];
    logic [15:0]        instr_mem_d [DEPTH];
    logic [15:0]        pc_mem_q    [DEPTH];
    logic [15:0]        pc_mem_d    [DEPTH];

    logic               pop;
    logic               push;
    logic               redir_take;
    logic               redir_ok;

    always_comb begin
        pop        = (count_q != '0) && bus.out_ready;
        redir_take = bus.redirect_valid && (state_q != ERROR);
        // 17-bit sum keeps targets near 16'hFFFF from wrapping back into range
        redir_ok   = (bus.redirect_addr[1:0] == 2'b00) &&
                     (({1'b0, bus.redirect_addr} + 17'd3) < MEM_LIMIT);
        push       = (state_q == FETCH) && !bus.redirect_valid &&
                     ((count_q < DEPTH_CNT) || pop);
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        if (push) begin
            instr_mem_d[tail_q] = bus.imem_instr;
            pc_mem_d[tail_q]    = fetch_pc_q;
            tail_d              = tail_q + 1'b1;
            fetch_pc_d          = fetch_pc_q + 16'd4;
            if (fetch_pc_q == LAST_PC) begin
                state_d = DRAIN;
            end
        end

        if (pop) begin
            head_d = head_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A head popped this cycle is already delivered; the rest is discarded
        if (redir_take) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (redir_ok) begin
                fetch_pc_d = bus.redirect_addr;
                state_d    = FETCH;
            end else begin
                state_d    = ERROR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            instr_mem_q <= '{default: '0};
            pc_mem_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    always_comb begin
        bus.imem_addr = (state_q == FETCH) ? fetch_pc_q : RESET_PC;
        bus.out_valid = (count_q != '0);
        bus.out_instr = instr_mem_q[head_q];
        bus.out_pc    = pc_mem_q[head_q];
        bus.done      = (state_q == DRAIN) && (count_q == '0);
        bus.err       = (state_q == ERROR);
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Directed self-checking bench for imem_fetch_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_fetch_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic addr_bad;

    imem_fetch_if bus ();

    imem_fetch_ctrl #(
        .DEPTH    (4),
        .MEM_SIZE (1024),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ROM image: words 0..3 are 16'h1111..16'h4444, everything else addr^A5A5
    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0000: rom_word = 16'h1111;
            16'h0004: rom_word = 16'h2222;
            16'h0008: rom_word = 16'h3333;
            16'h000C: rom_word = 16'h4444;
            default:  rom_word = a ^ 16'hA5A5;
        endcase
    endfunction

    assign bus.imem_instr = rom_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && ((bus.imem_addr > 16'd1020) || (bus.imem_addr[1:0] != 2'b00)))
            addr_bad <= 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] a);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = a;
        step();
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 16'h0000;
    endtask

    logic [15:0] exp_instr [4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        addr_bad = 1'b0;
        exp_instr[0] = 16'h1111;
        exp_instr[1] = 16'h2222;
        exp_instr[2] = 16'h3333;
        exp_instr[3] = 16'h4444;
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 16'h0000;
        bus.out_ready      = 1'b1;
        step();
        step();

        check("rst_imem_addr", bus.imem_addr, 16'h0000);
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_out_instr", bus.out_instr, 16'h0000);
        check("rst_out_pc",    bus.out_pc, 16'h0000);
        check("rst_done",      {15'd0, bus.done}, 16'd0);
        check("rst_err",       {15'd0, bus.err}, 16'd0);
        reset = 1'b0;

        // Streaming with out_ready held high
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", {15'd0, bus.out_valid}, 16'd1);
            check("stream_pc",    bus.out_pc, 16'(4 * i));
            check("stream_instr", bus.out_instr, exp_instr[i]);
        end

        // Backpressure: FIFO fills, fetch PC parks at 16
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("bp_imem_addr", bus.imem_addr, 16'd16);
        check("bp_head_pc",   bus.out_pc, 16'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("bp_drain_valid", {15'd0, bus.out_valid}, 16'd1);
            check("bp_drain_pc",    bus.out_pc, 16'(4 * i));
            step();
        end

        // Redirect while full with a pop in the same cycle
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        bus.out_ready = 1'b1;
        check("rd_popped_pc", bus.out_pc, 16'h0000);
        redirect(16'h0040);
        check("rd_gap_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rd_imem_addr", bus.imem_addr, 16'h0040);
        step();
        check("rd_valid", {15'd0, bus.out_valid}, 16'd1);
        check("rd_pc",    bus.out_pc, 16'h0040);
        check("rd_instr", bus.out_instr, 16'hA5E5);

        // End of memory
        redirect(16'h03F0);
        check("end_gap_valid", {15'd0, bus.out_valid}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("end_pc", bus.out_pc, 16'(16'h03F0 + 4 * i));
        end
        check("end_done_early", {15'd0, bus.done}, 16'd0);
        check("end_imem_addr",  bus.imem_addr, 16'h0000);
        step();
        check("end_done",  {15'd0, bus.done}, 16'd1);
        check("end_valid", {15'd0, bus.out_valid}, 16'd0);
        step();
        check("end_done_hold", {15'd0, bus.done}, 16'd1);
        redirect(16'h0000);
        check("restart_done",  {15'd0, bus.done}, 16'd0);
        check("restart_gap",   {15'd0, bus.out_valid}, 16'd0);
        step();
        check("restart_valid", {15'd0, bus.out_valid}, 16'd1);
        check("restart_pc",    bus.out_pc, 16'h0000);
        check("restart_instr", bus.out_instr, 16'h1111);

        // Misaligned target
        redirect(16'h0042);
        check("mis_err",   {15'd0, bus.err}, 16'd1);
        check("mis_valid", {15'd0, bus.out_valid}, 16'd0);
        check("mis_addr",  bus.imem_addr, 16'h0000);
        redirect(16'h0000);
        step();
        check("err_sticky",       {15'd0, bus.err}, 16'd1);
        check("err_valid_stays0", {15'd0, bus.out_valid}, 16'd0);

        // Asynchronous reset mid-cycle
        reset = 1'b1;
        #1;
        check("arst_err",   {15'd0, bus.err}, 16'd0);
        check("arst_valid", {15'd0, bus.out_valid}, 16'd0);
        check("arst_pc",    bus.out_pc, 16'h0000);
        reset = 1'b0;
        step();
        check("arst_restart_valid", {15'd0, bus.out_valid}, 16'd1);
        check("arst_restart_pc",    bus.out_pc, 16'h0000);

        // Highest legal target, then first illegal one
        redirect(16'h03FC);
        check("last_ok_err", {15'd0, bus.err}, 16'd0);
        step();
        check("last_pc",    bus.out_pc, 16'h03FC);
        check("last_instr", bus.out_instr, 16'hA659);
        step();
        check("last_done",  {15'd0, bus.done}, 16'd1);
        redirect(16'h0400);
        check("oob_err", {15'd0, bus.err}, 16'd1);
        do_reset();
        step();
        redirect(16'hFFFC);
        check("wrap_err", {15'd0, bus.err}, 16'd1);

        check("imem_addr_range", {15'd0, addr_bad}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
